// File: rtl/debug_loader.sv
// debug_loader: host-side loader/controller for the pipelined MIPS core.
// A UART byte stream loads 32-bit words into instruction memory. The core is
// then released and its cycles are counted until it halts. After a drain
// window the final result and the cycle count go back to the host, MSB first.
module debug_loader #(
  parameter int          IMEM_ADDR_W  = 8,
  parameter logic [31:0] END_WORD     = 32'hFFFF_FFFF,
  parameter int          DRAIN_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             i_rx_data,
  input  logic                   i_rx_valid,
  output logic [7:0]             o_tx_data,
  output logic                   o_tx_start,
  input  logic                   i_tx_busy,
  output logic                   o_imem_we,
  output logic [IMEM_ADDR_W-1:0] o_imem_addr,
  output logic [31:0]            o_imem_wdata,
  output logic                   o_core_reset,
  input  logic                   i_core_halt,
  input  logic [31:0]            i_core_result,
  output logic [2:0]             o_state
);

  // FSM state encodings (also exported on o_state for debug)
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_LOAD  = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_SEND  = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  // Per-byte transmit handshake phases
  localparam logic [1:0] TX_WAIT_IDLE = 2'd0;  // wait for TX to be free, then start
  localparam logic [1:0] TX_WAIT_BUSY = 2'd1;  // wait for TX to accept the byte
  localparam logic [1:0] TX_WAIT_DONE = 2'd2;  // wait for TX to finish the byte

  localparam logic [7:0] CMD_LOAD = 8'h4C;  // 'L'
  localparam logic [7:0] CMD_RUN  = 8'h52;  // 'R'

  // Drain counter sized for at least one bit; a drain of 0 behaves like 1
  localparam int DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  localparam logic [DRAIN_W-1:0] DRAIN_LAST = (DRAIN_CYCLES > 1) ? DRAIN_W'(DRAIN_CYCLES - 1) : '0;
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [IMEM_ADDR_W-1:0] ADDR_ONE = IMEM_ADDR_W'(1);

  logic [2:0]             state;
  logic [2:0]             state_next;
  logic [1:0]             byte_cnt;
  logic [31:0]            shift_word;
  logic [31:0]            assembled;
  logic [IMEM_ADDR_W-1:0] load_addr;
  logic                   load_last;
  logic [31:0]            cycle_cnt;
  logic [31:0]            result;
  logic [DRAIN_W-1:0]     drain_cnt;
  logic                   drain_last;
  logic [2:0]             tx_idx;
  logic [1:0]             tx_phase;
  logic                   tx_last_done;
  logic [63:0]            report;
  logic [7:0]             report_bytes [8];
  logic [7:0]             tx_byte;
  logic                   entering_load;
  logic                   entering_run;
  logic                   rx_is_load;
  logic                   rx_is_run;

  assign rx_is_load   = i_rx_valid && (i_rx_data == CMD_LOAD);
  assign rx_is_run    = i_rx_valid && (i_rx_data == CMD_RUN);
  assign assembled    = {shift_word[23:0], i_rx_data};
  assign drain_last   = (drain_cnt == DRAIN_LAST);
  assign tx_last_done = (tx_phase == TX_WAIT_DONE) && !i_tx_busy && (tx_idx == 3'd7);
  assign entering_load = (state_next == S_LOAD) && (state != S_LOAD);
  assign entering_run  = (state_next == S_RUN) && (state != S_RUN);
  assign o_state      = state;

  // Report image: result then cycle count, byte 0 is the first one sent
  assign report = {result, cycle_cnt};
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_report_bytes
      assign report_bytes[gi] = report[63 - 8*gi -: 8];
    end
  endgenerate
  assign tx_byte = report_bytes[tx_idx];

  // Next-state decode for the controller FSM
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: begin
        if (rx_is_load)     state_next = S_LOAD;
        else if (rx_is_run) state_next = S_RUN;
      end
      // The cycle that carries the final write moves on to RUN; any rx byte
      // arriving in that same cycle is dropped.
      S_LOAD:  if (load_last)    state_next = S_RUN;
      S_RUN:   if (i_core_halt)  state_next = S_DRAIN;
      S_DRAIN: if (drain_last)   state_next = S_SEND;
      S_SEND:  if (tx_last_done) state_next = S_DONE;
      default: state_next = S_IDLE;
    endcase
  end

  // State register; core reset follows the state being entered so the core
  // is released in the very first RUN cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      o_core_reset <= 1'b1;
    end else begin
      state        <= state_next;
      o_core_reset <= (state_next == S_IDLE) || (state_next == S_LOAD) || (state_next == S_DONE);
    end
  end

  // Byte assembler and instruction-memory write port
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byte_cnt     <= 2'd0;
      shift_word   <= 32'd0;
      load_addr    <= '0;
      load_last    <= 1'b0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= 32'd0;
    end else begin
      o_imem_we <= 1'b0;
      load_last <= 1'b0;
      if (entering_load) begin
        byte_cnt  <= 2'd0;
        load_addr <= '0;
      end else if ((state == S_LOAD) && !load_last && i_rx_valid) begin
        shift_word <= assembled;
        byte_cnt   <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          o_imem_we    <= 1'b1;
          o_imem_wdata <= assembled;
          o_imem_addr  <= load_addr;
          load_addr    <= load_addr + ADDR_ONE;
          // Stop on the end marker or on the last memory word; no wrap-around
          load_last    <= (assembled == END_WORD) || (load_addr == '1);
        end
      end
    end
  end

  // Run-cycle counter, drain window timer and result capture
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_cnt <= 32'd0;
      drain_cnt <= '0;
      result    <= 32'd0;
    end else begin
      if (entering_run) begin
        cycle_cnt <= 32'd0;
      end else if ((state == S_RUN) && !i_core_halt && (cycle_cnt != 32'hFFFF_FFFF)) begin
        cycle_cnt <= cycle_cnt + 32'd1;
      end

      if (state == S_RUN) begin
        drain_cnt <= '0;
      end else if ((state == S_DRAIN) && !drain_last) begin
        drain_cnt <= drain_cnt + DRAIN_ONE;
      end

      if ((state == S_DRAIN) && drain_last) begin
        result <= i_core_result;
      end
    end
  end

  // Report transmitter: one start pulse per byte, full busy handshake between bytes
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_idx     <= 3'd0;
      tx_phase   <= TX_WAIT_IDLE;
      o_tx_start <= 1'b0;
      o_tx_data  <= 8'd0;
    end else begin
      o_tx_start <= 1'b0;
      if (state != S_SEND) begin
        tx_idx   <= 3'd0;
        tx_phase <= TX_WAIT_IDLE;
      end else begin
        case (tx_phase)
          TX_WAIT_IDLE: begin
            if (!i_tx_busy) begin
              o_tx_start <= 1'b1;
              o_tx_data  <= tx_byte;
              tx_phase   <= TX_WAIT_BUSY;
            end
          end
          TX_WAIT_BUSY: begin
            if (i_tx_busy) tx_phase <= TX_WAIT_DONE;
          end
          TX_WAIT_DONE: begin
            if (!i_tx_busy) begin
              tx_idx   <= tx_idx + 3'd1;
              tx_phase <= TX_WAIT_IDLE;
            end
          end
          default: tx_phase <= TX_WAIT_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_debug_loader.sv
// Testbench for debug_loader: scoreboards for memory writes and TX bytes,
// a simple UART TX busy model, and one task per scenario.
module tb_debug_loader;

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_LOAD = 3'd1;
  localparam logic [2:0] ST_RUN  = 3'd2;
  localparam logic [2:0] ST_DONE = 3'd5;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_valid2;
  logic [7:0]  tx_data;
  logic        tx_start;
  logic        tx_busy;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        core_halt;
  logic [31:0] core_result;
  logic [2:0]  state;

  logic [7:0]  tx_data2;
  logic        tx_start2;
  logic        imem_we2;
  logic [1:0]  imem_addr2;
  logic [31:0] imem_wdata2;
  logic        core_reset2;
  logic [2:0]  state2;

  int checks_total  = 0;
  int checks_passed = 0;
  int tx_pulses     = 0;
  int tx_len        = 3;
  int busy_left     = 0;

  logic [39:0] exp_wr [$];
  logic [39:0] exp_wr2 [$];
  logic [7:0]  exp_tx [$];

  always #5 clk = ~clk;

  debug_loader #(.IMEM_ADDR_W(8), .END_WORD(32'hFFFF_FFFF), .DRAIN_CYCLES(4)) dut (
    .clk(clk), .reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(tx_data), .o_tx_start(tx_start), .i_tx_busy(tx_busy),
    .o_imem_we(imem_we), .o_imem_addr(imem_addr), .o_imem_wdata(imem_wdata),
    .o_core_reset(core_reset), .i_core_halt(core_halt), .i_core_result(core_result),
    .o_state(state)
  );

  debug_loader #(.IMEM_ADDR_W(2), .END_WORD(32'hFFFF_FFFF), .DRAIN_CYCLES(4)) dut2 (
    .clk(clk), .reset(reset), .i_rx_data(rx_data), .i_rx_valid(rx_valid2),
    .o_tx_data(tx_data2), .o_tx_start(tx_start2), .i_tx_busy(1'b0),
    .o_imem_we(imem_we2), .o_imem_addr(imem_addr2), .o_imem_wdata(imem_wdata2),
    .o_core_reset(core_reset2), .i_core_halt(1'b0), .i_core_result(32'd0),
    .o_state(state2)
  );

  // Write monitor (main DUT): every write must match the next expected one
  always @(negedge clk) begin
    if (imem_we) begin
      checks_total++;
      if (exp_wr.size() == 0) begin
        $display("FAIL wr_unexpected: got addr %0d data %h, want no write", imem_addr, imem_wdata);
      end else begin
        logic [39:0] e;
        e = exp_wr.pop_front();
        if ({imem_addr, imem_wdata} !== e)
          $display("FAIL wr_data: got addr %0d data %h, want addr %0d data %h",
                   imem_addr, imem_wdata, e[39:32], e[31:0]);
        else checks_passed++;
      end
    end
  end

  // Write monitor (small-memory DUT)
  always @(negedge clk) begin
    if (imem_we2) begin
      checks_total++;
      if (exp_wr2.size() == 0) begin
        $display("FAIL wr2_unexpected: got addr %0d data %h, want no write", imem_addr2, imem_wdata2);
      end else begin
        logic [39:0] e;
        e = exp_wr2.pop_front();
        if ({6'd0, imem_addr2, imem_wdata2} !== e)
          $display("FAIL wr2_data: got addr %0d data %h, want addr %0d data %h",
                   imem_addr2, imem_wdata2, e[39:32], e[31:0]);
        else checks_passed++;
      end
    end
  end

  // TX monitor plus UART busy model: busy rises the cycle after a start pulse
  always @(negedge clk) begin
    if (tx_start) begin
      tx_pulses++;
      checks_total++;
      if (tx_busy !== 1'b0) $display("FAIL tx_start_while_busy: got busy %b, want 0", tx_busy);
      else checks_passed++;
      checks_total++;
      if (exp_tx.size() == 0) begin
        $display("FAIL tx_unexpected: got byte %h, want no byte", tx_data);
      end else begin
        logic [7:0] e;
        e = exp_tx.pop_front();
        if (tx_data !== e) $display("FAIL tx_byte: got %h, want %h", tx_data, e);
        else checks_passed++;
      end
    end
    if (busy_left > 0) begin
      tx_busy = 1'b1;
      busy_left--;
    end else begin
      tx_busy = 1'b0;
    end
    if (tx_start) busy_left = tx_len;
  end

  task automatic send_byte(input bit to_small, input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    if (to_small) rx_valid2 = 1'b1; else rx_valid = 1'b1;
    @(negedge clk);
    rx_valid  = 1'b0;
    rx_valid2 = 1'b0;
  endtask

  task automatic push_report(input logic [31:0] res, input logic [31:0] cnt);
    logic [63:0] r;
    r = {res, cnt};
    for (int i = 0; i < 8; i++) exp_tx.push_back(r[63 - 8*i -: 8]);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checks_total++;
    if ({state, core_reset, imem_we, imem_addr, imem_wdata, tx_start, tx_data} !==
        {ST_IDLE, 1'b1, 1'b0, 8'd0, 32'd0, 1'b0, 8'd0})
      $display("FAIL reset_outputs: got state %0d crst %b we %b addr %h wd %h txs %b txd %h, want 0 1 0 0 0 0 0",
               state, core_reset, imem_we, imem_addr, imem_wdata, tx_start, tx_data);
    else checks_passed++;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks_total++;
    if (state !== ST_IDLE || core_reset !== 1'b1)
      $display("FAIL reset_idle: got state %0d crst %b, want 0 1", state, core_reset);
    else checks_passed++;
  endtask

  task automatic test_filter_idle;
    send_byte(0, 8'h41);
    send_byte(0, 8'h00);
    repeat (2) @(negedge clk);
    checks_total++;
    if (state !== ST_IDLE || core_reset !== 1'b1)
      $display("FAIL idle_filter: got state %0d crst %b, want 0 1", state, core_reset);
    else checks_passed++;
  endtask

  task automatic test_load;
    logic [7:0] bytes [12];
    bytes = '{8'h00, 8'h00, 8'h00, 8'h20, 8'h12, 8'h34, 8'h56, 8'h78, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    exp_wr.push_back({8'd0, 32'h0000_0020});
    exp_wr.push_back({8'd1, 32'h1234_5678});
    exp_wr.push_back({8'd2, 32'hFFFF_FFFF});
    send_byte(0, 8'h4C);
    for (int i = 0; i < 12; i++) send_byte(0, bytes[i]);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (state == ST_RUN) break;
    end
    checks_total++;
    if (state !== ST_RUN) $display("FAIL load_to_run: got state %0d, want 2", state);
    else checks_passed++;
    checks_total++;
    if (core_reset !== 1'b0) $display("FAIL load_core_release: got crst %b, want 0", core_reset);
    else checks_passed++;
    checks_total++;
    if (exp_wr.size() != 0) $display("FAIL load_writes_missing: got %0d pending, want 0", exp_wr.size());
    else checks_passed++;
  endtask

  task automatic wait_done(input string name, input int budget);
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (state == ST_DONE) break;
    end
    checks_total++;
    if (state !== ST_DONE || core_reset !== 1'b1)
      $display("FAIL %s_done: got state %0d crst %b, want 5 1", name, state, core_reset);
    else checks_passed++;
    checks_total++;
    if (exp_tx.size() != 0) $display("FAIL %s_tx_missing: got %0d pending, want 0", name, exp_tx.size());
    else checks_passed++;
  endtask

  // Entered at the first RUN cycle; halt is first seen after 10 counted cycles
  task automatic test_run_report;
    int p0;
    p0 = tx_pulses;
    push_report(32'h0000_ABCD, 32'd10);
    repeat (10) @(negedge clk);
    core_halt   = 1'b1;
    core_result = 32'h0000_ABCD;
    wait_done("run_report", 600);
    checks_total++;
    if (tx_pulses - p0 != 8) $display("FAIL run_report_pulses: got %0d, want 8", tx_pulses - p0);
    else checks_passed++;
  endtask

  task automatic test_run_filter;
    core_halt = 1'b0;
    push_report(32'h1234_5678, 32'd10);
    send_byte(0, 8'h52);  // ends on RUN cycle 1
    checks_total++;
    if (state !== ST_RUN || core_reset !== 1'b0)
      $display("FAIL rerun_enter: got state %0d crst %b, want 2 0", state, core_reset);
    else checks_passed++;
    send_byte(0, 8'h4C);
    for (int i = 0; i < 4; i++) send_byte(0, 8'h01 + 8'(i));  // now at RUN cycle 11
    checks_total++;
    if (state !== ST_RUN) $display("FAIL run_filter_state: got state %0d, want 2", state);
    else checks_passed++;
    core_halt   = 1'b1;
    core_result = 32'h1234_5678;
    wait_done("run_filter", 600);
  endtask

  task automatic test_halt_first(input int len, input logic [31:0] res, input string name);
    int p0;
    p0          = tx_pulses;
    tx_len      = len;
    core_halt   = 1'b1;
    core_result = res;
    push_report(res, 32'd0);
    send_byte(0, 8'h52);
    wait_done(name, 2000);
    checks_total++;
    if (tx_pulses - p0 != 8) $display("FAIL %s_pulses: got %0d, want 8", name, tx_pulses - p0);
    else checks_passed++;
    tx_len = 3;
  endtask

  task automatic test_reset_mid_load;
    core_halt = 1'b0;
    send_byte(0, 8'h4C);
    send_byte(0, 8'hAA);
    send_byte(0, 8'hBB);
    #2 reset = 1'b0;
    @(negedge clk);
    checks_total++;
    if (state !== ST_IDLE || core_reset !== 1'b1 || imem_we !== 1'b0)
      $display("FAIL midload_reset: got state %0d crst %b we %b, want 0 1 0", state, core_reset, imem_we);
    else checks_passed++;
    reset = 1'b1;
    exp_wr.push_back({8'd0, 32'h0102_0304});
    send_byte(0, 8'h4C);
    for (int i = 1; i <= 4; i++) send_byte(0, 8'(i));
    repeat (2) @(negedge clk);
    checks_total++;
    if (state !== ST_LOAD) $display("FAIL reload_state: got state %0d, want 1", state);
    else checks_passed++;
    checks_total++;
    if (exp_wr.size() != 0) $display("FAIL reload_write_missing: got %0d pending, want 0", exp_wr.size());
    else checks_passed++;
  endtask

  task automatic test_addr_limit;
    for (int k = 0; k < 4; k++) exp_wr2.push_back({8'(k), {4{8'(8'h11 * (k + 1))}}});
    send_byte(1, 8'h4C);
    for (int k = 0; k < 4; k++)
      for (int j = 0; j < 4; j++) send_byte(1, 8'(8'h11 * (k + 1)));
    for (int i = 0; i < 4; i++) send_byte(1, 8'h55);
    repeat (3) @(negedge clk);
    checks_total++;
    if (state2 !== ST_RUN || core_reset2 !== 1'b0)
      $display("FAIL addr_limit_run: got state %0d crst %b, want 2 0", state2, core_reset2);
    else checks_passed++;
    checks_total++;
    if (exp_wr2.size() != 0) $display("FAIL addr_limit_missing: got %0d pending, want 0", exp_wr2.size());
    else checks_passed++;
  endtask

  initial begin
    reset       = 1'b0;
    rx_data     = 8'd0;
    rx_valid    = 1'b0;
    rx_valid2   = 1'b0;
    tx_busy     = 1'b0;
    core_halt   = 1'b0;
    core_result = 32'd0;
    test_reset();
    test_filter_idle();
    test_load();
    test_run_report();
    test_run_filter();
    test_halt_first(3, 32'hDEAD_BEEF, "halt_first");
    test_halt_first(50, 32'hCAFE_0001, "backpressure");
    test_reset_mid_load();
    test_addr_limit();
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", checks_passed, checks_total);
    $finish;
  end

endmodule
